// File: rtl/alu_sequencer_if.sv
// Start/done handshake and result bus between the calculator FSM and alu_sequencer.
interface alu_sequencer_if;
  logic        start;
  logic        clr;
  logic [1:0]  op;
  logic [13:0] a;
  logic [13:0] b;
  logic        busy;
  logic        done;
  logic [13:0] result;
  logic        neg;
  logic        err;

  // Control FSM side
  modport master (
    output start, clr, op, a, b,
    input  busy, done, result, neg, err
  );

  // Arithmetic sequencer side
  modport slave (
    input  start, clr, op, a, b,
    output busy, done, result, neg, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer for 4-digit decimal operands held in binary.
// Short ops take one EXEC cycle; mul/div iterate 14 cycles. clr aborts without a done pulse.
module alu_sequencer (
  input logic           clk,
  input logic           resetn,
  alu_sequencer_if.slave bus
);

  localparam logic [13:0] MaxVal = 14'd9999;
  localparam logic [1:0]  OpAdd  = 2'b00;
  localparam logic [1:0]  OpSub  = 2'b01;
  localparam logic [1:0]  OpMul  = 2'b10;
  localparam logic [1:0]  OpDiv  = 2'b11;

  typedef enum logic [2:0] {StIdle, StExec, StMul, StDiv, StDone} state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [13:0] a_q;      // operand a; doubles as dividend/quotient shift register in DIV
  logic [13:0] b_q;      // operand b; doubles as multiplier shift register in MUL
  logic [3:0]  cnt_q;
  logic [27:0] acc_q;
  logic [27:0] mcand_q;
  logic [13:0] rem_q;
  logic        busy_q;
  logic        done_q;
  logic [13:0] result_q;
  logic        neg_q;
  logic        err_q;

  logic        in_valid;
  logic        last_iter;
  logic [14:0] sum;
  logic [27:0] acc_step;
  logic [14:0] rem_sh;
  logic        rem_ge;
  logic [13:0] rem_nxt;
  logic [13:0] quo_step;

  // Datapath for one EXEC step, one multiply iteration and one restoring-divide iteration
  always_comb begin
    in_valid  = (bus.a <= MaxVal) && (bus.b <= MaxVal);
    last_iter = (cnt_q == 4'd13);
    sum       = {1'b0, a_q} + {1'b0, b_q};
    acc_step  = b_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh    = {rem_q, a_q[13]};
    rem_ge    = (rem_sh >= {1'b0, b_q});
    // Remainder stays below the divisor, so it always fits back into 14 bits
    rem_nxt   = rem_ge ? 14'(rem_sh - {1'b0, b_q}) : rem_sh[13:0];
    quo_step  = {a_q[12:0], rem_ge};
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.clr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {14'd0, bus.a};
            rem_q    <= '0;
            busy_q   <= 1'b1;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            if (bus.op == OpMul && in_valid) begin
              state_q <= StMul;
            end else if (bus.op == OpDiv && in_valid && bus.b != 14'd0) begin
              state_q <= StDiv;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          state_q <= StDone;
          done_q  <= 1'b1;
          if (a_q > MaxVal || b_q > MaxVal) begin
            err_q <= 1'b1;
          end else begin
            case (op_q)
              OpAdd: begin
                if (sum > {1'b0, MaxVal}) err_q    <= 1'b1;
                else                      result_q <= sum[13:0];
              end
              OpSub: begin
                if (a_q >= b_q) begin
                  result_q <= a_q - b_q;
                end else begin
                  result_q <= b_q - a_q;
                  neg_q    <= 1'b1;
                end
              end
              // Only divide-by-zero lands here; valid multiplies always iterate
              default: err_q <= 1'b1;
            endcase
          end
        end
        StMul: begin
          acc_q   <= acc_step;
          mcand_q <= {mcand_q[26:0], 1'b0};
          b_q     <= {1'b0, b_q[13:1]};
          cnt_q   <= cnt_q + 4'd1;
          if (last_iter) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            if (acc_step > {14'd0, MaxVal}) err_q    <= 1'b1;
            else                            result_q <= acc_step[13:0];
          end
        end
        StDiv: begin
          rem_q <= rem_nxt;
          a_q   <= quo_step;
          cnt_q <= cnt_q + 4'd1;
          if (last_iter) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= quo_step;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer against an arithmetic reference model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations captured by run_op
  int          obs_done_cyc;
  int          obs_done_cnt;
  int          obs_busy_end;
  logic [13:0] obs_res;
  logic        obs_neg;
  logic        obs_err;
  logic [15:0] obs_hold;

  // Reference: expected result, sign, error and done cycle straight from the arithmetic rules
  function automatic void model(input int op, input int a, input int b,
                                output int r, output logic n, output logic e, output int lat);
    r = 0; n = 1'b0; e = 1'b0; lat = 2;
    if (a > 9999 || b > 9999) begin
      e = 1'b1;
    end else if (op == 0) begin
      if (a + b > 9999) e = 1'b1;
      else r = a + b;
    end else if (op == 1) begin
      if (a >= b) r = a - b;
      else begin r = b - a; n = 1'b1; end
    end else if (op == 2) begin
      lat = 15;
      if (a * b > 9999) e = 1'b1;
      else r = a * b;
    end else begin
      if (b == 0) e = 1'b1;
      else begin lat = 15; r = a / b; end
    end
  endfunction

  // Issue one start at the next edge and watch cycles 1..20; ends aligned #1 after an edge
  task automatic run_op(input int op, input int a, input int b);
    obs_done_cyc = 0; obs_done_cnt = 0; obs_busy_end = 0;
    obs_res = '0; obs_neg = 1'b0; obs_err = 1'b0;
    bus.op = op[1:0]; bus.a = a[13:0]; bus.b = b[13:0]; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) begin
          obs_done_cyc = c; obs_res = bus.result; obs_neg = bus.neg; obs_err = bus.err;
        end
      end
      if (!bus.busy && obs_busy_end == 0) obs_busy_end = c;
      @(posedge clk); #1;
    end
    obs_hold = {bus.result, bus.neg, bus.err};
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.clr = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.neg, bus.err} !== 18'd0)
      $display("FAIL reset_hold: outputs got %h want 0",
               {bus.busy, bus.done, bus.result, bus.neg, bus.err});
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.neg, bus.err} !== 18'd0) begin
      errors++;
      $display("FAIL reset_release: outputs got %h want 0",
               {bus.busy, bus.done, bus.result, bus.neg, bus.err});
    end
    // Reset in the middle of a multiply
    bus.op = 2'b10; bus.a = 14'd99; bus.b = 14'd99; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mul_busy: busy got %b want 1", bus.busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.neg, bus.err} !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: outputs got %h want 0",
               {bus.busy, bus.done, bus.result, bus.neg, bus.err});
    end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    run_op(0, 1234, 4321);
    checks++;
    if (obs_done_cyc !== 2 || obs_res !== 14'd5555 || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL reset_recover: done_cyc/result/count got %0d/%0d/%0d want 2/5555/1",
               obs_done_cyc, obs_res, obs_done_cnt);
    end
  endtask

  // add, sub, divide-by-zero and invalid operands: all take the short path
  task automatic test_exec_ops();
    int tab_op[5] = '{0, 0, 1, 3, 0};
    int tab_a[5]  = '{1234, 9000, 25, 5, 12000};
    int tab_b[5]  = '{4321, 1000, 100, 0, 7};
    for (int i = 0; i < 17; i++) begin
      int op, a, b, er, lat;
      logic en, ee;
      if (i < 5) begin
        op = tab_op[i]; a = tab_a[i]; b = tab_b[i];
      end else begin
        op = int'($urandom_range(0, 3));
        a  = int'($urandom_range(0, 9999));
        b  = int'($urandom_range(0, 9999));
        if (op == 2) a = int'($urandom_range(10000, 16383));
        if (op == 3) b = 0;
        if (op < 2 && $urandom_range(0, 5) == 0) b = int'($urandom_range(10000, 16383));
      end
      model(op, a, b, er, en, ee, lat);
      run_op(op, a, b);
      checks++;
      if (obs_done_cyc !== lat) begin
        errors++;
        $display("FAIL exec_done_cycle op=%0d a=%0d b=%0d: got %0d want %0d",
                 op, a, b, obs_done_cyc, lat);
      end
      checks++;
      if (obs_done_cnt !== 1) begin
        errors++;
        $display("FAIL exec_done_count op=%0d a=%0d b=%0d: got %0d want 1",
                 op, a, b, obs_done_cnt);
      end
      checks++;
      if (obs_busy_end !== lat + 1) begin
        errors++;
        $display("FAIL exec_busy_end op=%0d a=%0d b=%0d: got %0d want %0d",
                 op, a, b, obs_busy_end, lat + 1);
      end
      checks++;
      if ({obs_res, obs_neg, obs_err} !== {er[13:0], en, ee}) begin
        errors++;
        $display("FAIL exec_result op=%0d a=%0d b=%0d: got r=%0d n=%b e=%b want r=%0d n=%b e=%b",
                 op, a, b, obs_res, obs_neg, obs_err, er, en, ee);
      end
      checks++;
      if (obs_hold !== {er[13:0], en, ee}) begin
        errors++;
        $display("FAIL exec_hold op=%0d a=%0d b=%0d: got %h want %h",
                 op, a, b, obs_hold, {er[13:0], en, ee});
      end
    end
  endtask

  // Multiply and divide: 14 iterations, done in cycle 15
  task automatic test_iterative();
    int tab_op[4] = '{2, 2, 3, 3};
    int tab_a[4]  = '{99, 100, 9999, 0};
    int tab_b[4]  = '{99, 100, 7, 5};
    for (int i = 0; i < 14; i++) begin
      int op, a, b, er, lat;
      logic en, ee;
      if (i < 4) begin
        op = tab_op[i]; a = tab_a[i]; b = tab_b[i];
      end else if (i % 2 == 0) begin
        op = 2; a = int'($urandom_range(0, 200)); b = int'($urandom_range(0, 200));
      end else begin
        op = 3; a = int'($urandom_range(0, 9999)); b = int'($urandom_range(1, 9999));
        if (i % 3 == 0) b = int'($urandom_range(1, 40));
      end
      model(op, a, b, er, en, ee, lat);
      run_op(op, a, b);
      checks++;
      if (obs_done_cyc !== lat) begin
        errors++;
        $display("FAIL iter_done_cycle op=%0d a=%0d b=%0d: got %0d want %0d",
                 op, a, b, obs_done_cyc, lat);
      end
      checks++;
      if (obs_done_cnt !== 1) begin
        errors++;
        $display("FAIL iter_done_count op=%0d a=%0d b=%0d: got %0d want 1",
                 op, a, b, obs_done_cnt);
      end
      checks++;
      if (obs_busy_end !== lat + 1) begin
        errors++;
        $display("FAIL iter_busy_end op=%0d a=%0d b=%0d: got %0d want %0d",
                 op, a, b, obs_busy_end, lat + 1);
      end
      checks++;
      if ({obs_res, obs_neg, obs_err} !== {er[13:0], en, ee}) begin
        errors++;
        $display("FAIL iter_result op=%0d a=%0d b=%0d: got r=%0d n=%b e=%b want r=%0d n=%b e=%b",
                 op, a, b, obs_res, obs_neg, obs_err, er, en, ee);
      end
      checks++;
      if (obs_hold !== {er[13:0], en, ee}) begin
        errors++;
        $display("FAIL iter_hold op=%0d a=%0d b=%0d: got %h want %h",
                 op, a, b, obs_hold, {er[13:0], en, ee});
      end
    end
  endtask

  // start during MUL is dropped; start held across EXEC/DONE is taken only once IDLE
  task automatic test_handshake();
    int dcnt, dcyc, d1, d2;
    logic [13:0] r1, r2;
    logic n2;
    bus.op = 2'b10; bus.a = 14'd99; bus.b = 14'd99; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcnt = 0; dcyc = 0; r1 = '0;
    for (int c = 1; c <= 25; c++) begin
      if (bus.done) begin
        dcnt++;
        if (dcyc == 0) begin dcyc = c; r1 = bus.result; end
      end
      if (c == 5) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 14'd1; bus.b = 14'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dcnt !== 1 || dcyc !== 15 || r1 !== 14'd9801) begin
      errors++;
      $display("FAIL start_during_mul: count/cycle/result got %0d/%0d/%0d want 1/15/9801",
               dcnt, dcyc, r1);
    end
    // Back to back: start held high from edge 0 through edge 3
    bus.op = 2'b00; bus.a = 14'd1234; bus.b = 14'd4321; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.op = 2'b01; bus.a = 14'd25; bus.b = 14'd100;
    dcnt = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0; n2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) bus.start = 1'b0;
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = c; r1 = bus.result; end
        if (dcnt == 2) begin d2 = c; r2 = bus.result; n2 = bus.neg; end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (dcnt !== 2) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d want 2", dcnt);
    end
    checks++;
    if (d1 !== 2 || r1 !== 14'd5555) begin
      errors++;
      $display("FAIL back_to_back_first: cycle/result got %0d/%0d want 2/5555", d1, r1);
    end
    checks++;
    if (d2 !== 5 || r2 !== 14'd75 || n2 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_second: cycle/result/neg got %0d/%0d/%b want 5/75/1",
               d2, r2, n2);
    end
  endtask

  task automatic test_abort();
    int dcnt;
    logic busy_seen;
    bus.op = 2'b11; bus.a = 14'd9999; bus.b = 14'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcnt = 0;
    for (int c = 1; c < 7; c++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.neg, bus.err} !== 18'd0) begin
      errors++;
      $display("FAIL abort_div: outputs got %h want 0",
               {bus.busy, bus.done, bus.result, bus.neg, bus.err});
    end
    for (int c = 0; c < 16; c++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (dcnt !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses got %0d want 0", dcnt);
    end
    // clr and start together in IDLE, with a held result to clear
    run_op(0, 1234, 4321);
    bus.op = 2'b00; bus.a = 14'd1; bus.b = 14'd1; bus.start = 1'b1; bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.clr = 1'b0;
    checks++;
    if (bus.result !== 14'd0) begin
      errors++;
      $display("FAIL clr_start_clears: result got %0d want 0", bus.result);
    end
    dcnt = 0; busy_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done) dcnt++;
      if (bus.busy) busy_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (dcnt !== 0 || busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_dropped: done count/busy got %0d/%b want 0/0", dcnt, busy_seen);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.clr = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    test_reset();
    test_exec_ops();
    test_iterative();
    test_handshake();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle arithmetic controller between the calculator control FSM and the result/display path. It accepts two 4-digit decimal operands, in binary form, plus an operator through a start/done handshake. It sequences one add/subtract step, or a 14-iteration shift-add multiply or restoring divide, and returns a range-checked result with sign and error flags. It also handles the Clear key as a synchronous abort.

## Interface
- No parameters; operand width fixed at 14 bits (max legal value 9999).
- clk  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- clr  in  1  synchronous abort/clear (C key); priority over everything but reset
- op  in  2  00 add, 01 sub, 10 mul, 11 div; latched with start
- a  in  14  first operand, latched with start
- b  in  14  second operand, latched with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result fields valid
- result  out  14  magnitude of result; held until next accepted start or clr
- neg  out  1  result negative (sub only)
- err  out  1  overflow, divide-by-zero or invalid operand

## Operation
- States: IDLE, EXEC, MUL, DIV, DONE.
- IDLE + start=1: latch a, b, op; clear result/neg/err; iteration counter=0.
  - Next state is MUL for op=10 with valid operands.
  - Next state is DIV for op=11 with valid operands and b≠0.
  - Next state is EXEC otherwise.
- EXEC (1 cycle) computes and writes result/neg/err, then goes to DONE.
  - Any operand >9999: err=1, result=0, neg=0, regardless of op.
  - add: sum >9999 → err=1, result=0; else result=a+b.
  - sub: a≥b → result=a−b, neg=0; a<b → result=b−a, neg=1.
  - div with b=0: err=1, result=0.
- MUL: 28-bit accumulator, multiplier shifted right one bit per cycle; exactly 14 cycles.
  - On the last cycle: product >9999 → err=1, result=0; else result=product[13:0].
  - Then goes to DONE.
- DIV: restoring division MSB-first; exactly 14 cycles.
  - result=floor(a/b); the remainder is discarded.
  - Then goes to DONE.
- DONE (1 cycle): done=1, then IDLE.
- start outside IDLE is ignored. It is not queued.
- clr=1 in any state: next state IDLE; result, neg and err cleared; counter cleared; no done pulse.
  - clr and start in the same IDLE cycle: clr wins and start is dropped.
- err=1 always forces result=0 and neg=0.

## Timing
- Reset values: busy=0, done=0, result=0, neg=0, err=0, state IDLE, counter 0.
- Cycle numbering: start sampled high at edge 0.
- add/sub/div-by-zero/invalid-operand:
  - EXEC during cycle 1; DONE during cycle 2.
  - done=1 during cycle 2; busy=1 during cycles 1–2.
- mul/div:
  - iterations during cycles 1–14; DONE during cycle 15.
  - busy=1 during cycles 1–15.
- Earliest next accepted start: edge after DONE, i.e. cycle 3 for short ops and cycle 16 for mul/div.
- result/neg/err are registered, valid from the done cycle, and stable until the next accepted start or clr.
- Reset mid-operation: immediate return to reset values; no done pulse.

## Test plan
- Reset: assert resetn=0 mid-MUL → all outputs 0 at once; after release, busy=0 and start accepted.
- add/sub, on three separate starts:
  - 1234+4321 → done in cycle 2, result=5555, err=0.
  - 9000+1000 → err=1, result=0.
  - 25−100 → result=75, neg=1.
- mul:
  - 99×99 → done in cycle 15, result=9801, busy high cycles 1–15.
  - 100×100 → err=1, result=0.
- div:
  - 9999/7 → result=1428, done in cycle 15.
  - 5/0 → err=1, result=0, done in cycle 2.
  - a=12000 with op=add → err=1.
- Handshake:
  - start pulsed during MUL cycle 5 → ignored; exactly one done.
  - start re-asserted in the cycle after DONE → accepted.
- Abort: clr at DIV cycle 7 → IDLE next edge, result=0, err=0, no done.
  - clr and start together in IDLE → no busy, no done.
